// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end owning the PC, issuing one fetch per grant
// and buffering returned instructions with PC and PC+INC in a DEPTH-entry FIFO.
module fetch_queue #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0,
  parameter int INC      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_pc_inc,
  output logic [31:0]                out_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {BOOT, RUN} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] pc, rec_pc;
  logic inflight, grant, push, pop;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [XLEN-1:0] pc_inc_q [DEPTH];
  logic [31:0] inst_q [DEPTH];
  always_comb begin
    state_nx = RUN;
    imem_req = (state == RUN) && !redirect && ((count + CW'(inflight)) < CW'(DEPTH));
    grant = imem_req && imem_gnt;
    push = imem_rvalid && inflight && !redirect;
    pop = out_valid && out_ready && !redirect;
  end
  assign imem_addr = pc;
  assign out_valid = count != '0;
  assign out_pc = pc_q[rd_ptr];
  assign out_pc_inc = pc_inc_q[rd_ptr];
  assign out_inst = inst_q[rd_ptr];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BOOT;
    else state <= state_nx;
  end
  // Redirect wins over everything: same-cycle push, pop and pending response are all dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= XLEN'(RESET_PC);
      rec_pc <= '0;
      inflight <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= '0;
        pc_inc_q[i] <= '0;
        inst_q[i] <= '0;
      end
    end else if (redirect) begin
      pc <= redirect_pc & ~XLEN'(3);
      inflight <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (grant) begin
        pc <= pc + XLEN'(INC);
        rec_pc <= pc;
      end
      inflight <= grant;
      if (push) begin
        pc_q[wr_ptr] <= rec_pc;
        pc_inc_q[wr_ptr] <= rec_pc + XLEN'(INC);
        inst_q[wr_ptr] <= imem_rdata;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue with a table of traffic phases
// and hand-written redirect, wrap-around and mid-operation reset sequences.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h100;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic imem_req, imem_gnt, imem_rvalid, redirect, out_valid, out_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, out_pc, out_pc_inc, out_inst;
  logic [2:0] count;
  typedef struct {logic [31:0] pc, pc_inc, inst;} ent_t;
  typedef struct {int gnt_mode; logic ready; int cycles; int exp_cnt;} vec_t;
  ent_t q[$];
  vec_t vecs[4];
  int checks = 0, errors = 0, exp_count = 0, last_count = 0;
  logic infl = 1'b0, run = 1'b0;
  logic [31:0] exp_pc = RPC;
  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h100), .INC(4)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_inc(out_pc_inc), .out_inst(out_inst), .count(count)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    logic exp_req, pop, bus_gnt;
    logic [31:0] bus_addr;
    ent_t e;
    @(negedge clk);
    exp_req = run && !redirect && (q.size() < DEPTH);
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, exp_pc);
    chk("count", {29'b0, count}, exp_count);
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_count != 0});
    last_count = int'(count);
    pop = exp_count > 0 && out_ready && !redirect;
    if (pop) begin
      e = q.pop_front();
      chk("out_pc", out_pc, e.pc);
      chk("out_pc_inc", out_pc_inc, e.pc_inc);
      chk("out_inst", out_inst, e.inst);
    end
    bus_gnt = imem_req && imem_gnt;
    bus_addr = imem_addr;
    if (redirect) begin
      q.delete();
      infl = 1'b0;
      exp_count = 0;
      exp_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      exp_count = exp_count + int'(infl) - int'(pop);
      infl = exp_req && imem_gnt;
      if (infl) begin
        q.push_back('{exp_pc, exp_pc + 32'd4, mem_data(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
    end
    run = 1'b1;
    @(posedge clk);
    #1;
    imem_rvalid = bus_gnt;
    imem_rdata = bus_gnt ? mem_data(bus_addr) : 32'h0;
  endtask
  task automatic check_reset_vals();
    chk("rst imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst imem_addr", imem_addr, RPC);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst out_pc", out_pc, 32'd0);
    chk("rst out_pc_inc", out_pc_inc, 32'd0);
    chk("rst out_inst", out_inst, 32'd0);
    chk("rst count", {29'b0, count}, 32'd0);
  endtask
  initial begin
    int n;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    vecs[0] = '{1, 1'b1, 10, 1};
    vecs[1] = '{1, 1'b0, 8, 4};
    vecs[2] = '{1, 1'b1, 10, 2};
    vecs[3] = '{2, 1'b1, 12, 1};
    #12;
    check_reset_vals();
    @(posedge clk);
    #1;
    rst = 1'b1;
    foreach (vecs[v]) begin
      for (int i = 0; i < vecs[v].cycles; i++) begin
        imem_gnt = vecs[v].gnt_mode == 2 ? (i % 2 == 1) : vecs[v].gnt_mode == 1;
        out_ready = vecs[v].ready;
        step();
      end
      chk($sformatf("phase%0d count", v), last_count, vecs[v].exp_cnt);
    end
    imem_gnt = 1'b1; out_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 32'h403;
    step();
    redirect = 1'b0;
    #1;
    chk("redir count", {29'b0, count}, 32'd0);
    chk("redir addr", imem_addr, 32'h400);
    step();
    step();
    chk("redir head valid", {31'b0, out_valid}, 32'd1);
    chk("redir head pc", out_pc, 32'h400);
    for (int i = 0; i < 4; i++) step();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    step();
    chk("wrap addr", imem_addr, 32'h0);
    for (int i = 0; i < 6; i++) step();
    out_ready = 1'b0;
    n = 0;
    while (!(exp_count == 3 && infl) && n < 20) begin
      step();
      n++;
    end
    chk("midrst reached", {31'b0, exp_count == 3 && infl}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals();
    q.delete();
    infl = 1'b0; run = 1'b0; exp_count = 0; exp_pc = RPC;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
